// File: rtl/sound_pkg.sv
// Shared sound constants for the car simulator piezo path.
// Half-periods are in 50 MHz clocks.
package sound_pkg;

   localparam int DEF_PERIOD_W = 20;
   localparam int DEF_DUR_W    = 25;

   localparam int NOTE_C4 = 95554;
   localparam int NOTE_D4 = 85132;
   localparam int NOTE_E4 = 75843;
   localparam int NOTE_F4 = 71586;
   localparam int NOTE_G4 = 63776;
   localparam int NOTE_A4 = 56818;
   localparam int NOTE_B4 = 50619;
   localparam int NOTE_C5 = 47778;
   localparam int NOTE_D5 = 42566;
   localparam int NOTE_E5 = 37921;

   localparam int CLICK_HI = 12500;
   localparam int CLICK_LO = 15625;
   localparam int HORN     = 62500;

endpackage

// File: rtl/tone_channel.sv
// One tone channel: one-shot countdown, tone counter and square-wave level.
// Active while the level request is held or a one-shot is pending.
module tone_channel
   import sound_pkg::*;
#(
   parameter int PERIOD_W = DEF_PERIOD_W,
   parameter int DUR_W    = DEF_DUR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic                trig,
   input  logic [PERIOD_W-1:0] period,
   input  logic [DUR_W-1:0]    dur,
   output logic                active,
   output logic                wave
);

   logic [DUR_W-1:0]    dur_cnt;
   logic [PERIOD_W-1:0] tone_cnt;

   assign active = req | (dur_cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dur_cnt  <= '0;
         tone_cnt <= '0;
         wave     <= 1'b0;
      end else begin
         if (trig && (dur != '0))
            dur_cnt <= dur;
         else if (dur_cnt != '0)
            dur_cnt <= dur_cnt - 1'b1;

         // >= so a period shortened mid-tone wraps at once
         if (active && (period != '0)) begin
            if (tone_cnt >= period) begin
               tone_cnt <= '0;
               wave     <= ~wave;
            end else begin
               tone_cnt <= tone_cnt + 1'b1;
            end
         end else begin
            tone_cnt <= '0;
            wave     <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/piezo_tone_arbiter.sv
// Multi-channel tone generator with fixed-priority arbitration
// onto the single piezo output; channel 0 wins.
module piezo_tone_arbiter
   import sound_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int PERIOD_W = DEF_PERIOD_W,
   parameter int DUR_W    = DEF_DUR_W,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_req,
   input  logic [NUM_CH-1:0]          ch_trig,
   input  logic [NUM_CH*PERIOD_W-1:0] ch_period,
   input  logic [NUM_CH*DUR_W-1:0]    ch_dur,
   input  logic                       mute,
   output logic                       piezo_out,
   output logic [CH_W-1:0]            active_ch,
   output logic                       busy
);

   logic [NUM_CH-1:0] active;
   logic [NUM_CH-1:0] wave;
   logic [CH_W-1:0]   win;
   logic              busy_next;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tone_channel #(
         .PERIOD_W (PERIOD_W),
         .DUR_W    (DUR_W)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .req    (ch_req[g]),
         .trig   (ch_trig[g]),
         .period (ch_period[g*PERIOD_W +: PERIOD_W]),
         .dur    (ch_dur[g*DUR_W +: DUR_W]),
         .active (active[g]),
         .wave   (wave[g])
      );
   end

   // Scan downward so the lowest active index is left in win
   always_comb begin
      win = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (active[i])
            win = CH_W'(i);
      end
   end

   assign busy_next = |active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         piezo_out <= 1'b0;
         active_ch <= '0;
         busy      <= 1'b0;
      end else begin
         piezo_out <= (busy_next & ~mute) ? wave[win] : 1'b0;
         active_ch <= win;
         busy      <= busy_next;
      end
   end

endmodule

// File: tb/tb_piezo_tone_arbiter.sv
// Scoreboard bench for piezo_tone_arbiter: directed scenarios plus
// random episodes against a counting reference model.
module tb_piezo_tone_arbiter;

   localparam int NUM_CH   = 4;
   localparam int PERIOD_W = 20;
   localparam int DUR_W    = 25;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic [NUM_CH-1:0]          ch_req = '0;
   logic [NUM_CH-1:0]          ch_trig = '0;
   logic [NUM_CH*PERIOD_W-1:0] ch_period = '0;
   logic [NUM_CH*DUR_W-1:0]    ch_dur = '0;
   logic                       mute = 1'b0;
   logic                       piezo_out;
   logic [1:0]                 active_ch;
   logic                       busy;

   piezo_tone_arbiter #(
      .NUM_CH   (NUM_CH),
      .PERIOD_W (PERIOD_W),
      .DUR_W    (DUR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ch_req    (ch_req),
      .ch_trig   (ch_trig),
      .ch_period (ch_period),
      .ch_dur    (ch_dur),
      .mute      (mute),
      .piezo_out (piezo_out),
      .active_ch (active_ch),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       piezo;
      logic [1:0] ch;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   busy_seen = 0;

   bit s_req[NUM_CH];
   bit s_trig[NUM_CH];
   bit s_mute;
   int s_per[NUM_CH];
   int s_dur[NUM_CH];

   // Model: remaining one-shot clocks and active edges since activation
   int rem[NUM_CH];
   int ph[NUM_CH];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit wave_of(int i);
      if (s_per[i] == 0) return 1'b0;
      return ((ph[i] / (s_per[i] + 1)) % 2) == 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         rem[i] = 0;
         ph[i]  = 0;
      end
   endtask

   task automatic step();
      exp_t e;
      bit   act[NUM_CH];
      int   win;
      bit   any;
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
         ch_req[i]  = s_req[i];
         ch_trig[i] = s_trig[i];
         ch_period[i*PERIOD_W +: PERIOD_W] = PERIOD_W'(s_per[i]);
         ch_dur[i*DUR_W +: DUR_W] = DUR_W'(s_dur[i]);
      end
      mute = s_mute;
      e = '0;
      if (rst) begin
         model_reset();
      end else begin
         any = 0;
         win = 0;
         for (int i = 0; i < NUM_CH; i++)
            act[i] = s_req[i] || (rem[i] != 0);
         for (int i = NUM_CH - 1; i >= 0; i--)
            if (act[i]) begin
               win = i;
               any = 1;
            end
         e.busy  = any;
         e.ch    = 2'(win);
         e.piezo = any && !s_mute && wave_of(win);
         for (int i = 0; i < NUM_CH; i++) begin
            if (s_trig[i] && s_dur[i] > 0) rem[i] = s_dur[i];
            else if (rem[i] > 0) rem[i] = rem[i] - 1;
            if (act[i] && s_per[i] != 0) ph[i] = ph[i] + 1;
            else ph[i] = 0;
         end
      end
      sb.push_back(e);
      for (int i = 0; i < NUM_CH; i++) s_trig[i] = 0;
   endtask

   task automatic steps(int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic go_idle();
      bit pend;
      for (int i = 0; i < NUM_CH; i++) s_req[i] = 0;
      s_mute = 0;
      for (int k = 0; k < 200; k++) begin
         pend = 0;
         for (int i = 0; i < NUM_CH; i++) if (rem[i] != 0) pend = 1;
         if (!pend) break;
         step();
      end
      steps(2);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("piezo_out", 32'(piezo_out), 32'(e.piezo));
            check("active_ch", 32'(active_ch), 32'(e.ch));
            check("busy", 32'(busy), 32'(e.busy));
         end
         if (busy === 1'b1) busy_seen++;
      end
   end

   initial begin : driver
      for (int i = 0; i < NUM_CH; i++) begin
         s_req[i] = 0; s_trig[i] = 0; s_per[i] = 0; s_dur[i] = 0;
      end
      s_mute = 0;
      model_reset();
      steps(3);
      rst = 1'b0;
      steps(2);

      // Single level request, half-period 4
      s_per[1] = 4;
      s_req[1] = 1;
      steps(40);
      go_idle();

      // Priority takeover and phase continuity of the loser
      s_per[2] = 25;
      s_per[0] = 5;
      s_req[2] = 1;
      steps(30);
      s_req[0] = 1;
      steps(40);
      s_req[0] = 0;
      steps(60);
      go_idle();

      // Trigger with zero duration does nothing
      s_dur[0] = 0;
      s_trig[0] = 1;
      steps(5);

      // One-shot with retrigger at cycle 1000
      s_per[3] = 7;
      s_dur[3] = 1500;
      busy_seen = 0;
      s_trig[3] = 1;
      step();
      steps(999);
      s_trig[3] = 1;
      step();
      steps(1600);
      check("oneshot_busy_len", 32'(busy_seen), 32'd2500);
      go_idle();

      // Rest channel masks a sounding lower-priority channel
      s_per[0] = 0;
      s_per[1] = 100;
      s_req[0] = 1;
      s_req[1] = 1;
      steps(300);
      go_idle();

      // Mute keeps generators running
      s_per[1] = 6;
      s_req[1] = 1;
      steps(23);
      s_mute = 1;
      steps(37);
      s_mute = 0;
      steps(40);
      go_idle();

      // Asynchronous reset in the middle of a one-shot
      s_per[2] = 3;
      s_dur[2] = 400;
      s_trig[2] = 1;
      steps(50);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_piezo", 32'(piezo_out), 32'd0);
      check("rst_active_ch", 32'(active_ch), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      model_reset();
      steps(3);
      rst = 1'b0;
      steps(50);

      // Random episodes; periods only change while everything is idle
      for (int ep = 0; ep < 20; ep++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            s_per[i] = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(20, 1));
            s_dur[i] = int'($urandom_range(60, 1));
         end
         for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if ($urandom_range(24) == 0) s_req[i] = !s_req[i];
               s_trig[i] = ($urandom_range(29) == 0);
            end
            if ($urandom_range(49) == 0) s_mute = !s_mute;
            step();
         end
         go_idle();
      end

      @(posedge clk);
      #3;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
